// File: rtl/csr_exec.sv
// csr_exec: Zicsr execute unit; side-effect-free CHECK cycle, then COMMIT write, then RESP.
// Latency 3 cycles accept-to-out_valid; in_ready only in IDLE; RESP holds until out_ready or flush.
// Optional macro CSR_RO_TRAP_EN: writes to csr[11:10]=11 trap instead of being silently dropped.
module csr_exec (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs1,
  input  logic [31:0] in_rs1_data,
  input  logic [4:0]  in_rd,
  input  logic [11:0] in_csr,
  input  logic [29:0] in_pc,
  input  logic [31:0] in_insn,
  input  logic        flush,
  output logic [11:0] csr_addr,
  output logic [1:0]  csr_write,
  output logic [31:0] csr_wdata,
  input  logic        csr_error,
  input  logic [31:0] csr_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_exc,
  output logic [3:0]  out_exc_cause,
  output logic [29:0] out_pc
);

  localparam logic [3:0] IILLEGAL = 4'd2;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, RESP} state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [31:0] rs1_data;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [29:0] pc;
    logic [31:0] insn;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q;
  logic [31:0] old_q;
  logic        illegal_q;

  logic [1:0]  op;
  logic        wr_needed;
  logic        ro_space;
  logic        ro_drop;
  logic        illegal_c;
  logic        accept;

  assign op        = req_q.funct3[1:0];
  // CSRRW always writes; set/clear with rs1/zimm of zero is a pure read
  assign wr_needed = (op == 2'b01) || (req_q.rs1 != 5'd0);
  assign ro_space  = (req_q.csr[11:10] == 2'b11);

`ifdef CSR_RO_TRAP_EN
  assign illegal_c = (op == 2'b00) || csr_error || (wr_needed && ro_space);
  assign ro_drop   = 1'b0;
`else
  assign illegal_c = (op == 2'b00) || csr_error;
  assign ro_drop   = ro_space;
`endif

  assign accept = (state_q == IDLE) && in_valid && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.funct3   <= in_funct3;
        req_q.rs1      <= in_rs1;
        req_q.rs1_data <= in_rs1_data;
        req_q.rd       <= in_rd;
        req_q.csr      <= in_csr;
        req_q.pc       <= in_pc;
        req_q.insn     <= in_insn;
      end
      if (state_q == CHECK) begin
        old_q     <= csr_rdata;
        illegal_q <= illegal_c;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    csr_write = 2'b00;
    case (state_q)
      IDLE:   if (accept) state_d = CHECK;
      CHECK:  state_d = flush ? IDLE : COMMIT;
      COMMIT: begin
        if (wr_needed && !illegal_q && !ro_drop && !flush) csr_write = op;
        state_d = flush ? IDLE : RESP;
      end
      RESP:   if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign csr_addr      = req_q.csr;
  assign csr_wdata     = req_q.funct3[2] ? {27'd0, req_q.rs1} : req_q.rs1_data;

  assign out_valid     = (state_q == RESP);
  assign out_rd        = illegal_q ? 5'd0 : req_q.rd;
  assign out_data      = illegal_q ? req_q.insn : old_q;
  assign out_exc       = illegal_q;
  assign out_exc_cause = illegal_q ? IILLEGAL : 4'd0;
  assign out_pc        = req_q.pc;

endmodule

// File: tb/tb_csr_exec.sv
// Bench for csr_exec: small CSR-file model on the port, scoreboard of expected writeback results.
module tb_csr_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [31:0] in_rs1_data;
  logic [4:0]  in_rd;
  logic [11:0] in_csr;
  logic [29:0] in_pc;
  logic [31:0] in_insn;
  logic        flush;
  logic [11:0] csr_addr;
  logic [1:0]  csr_write;
  logic [31:0] csr_wdata;
  logic        csr_error;
  logic [31:0] csr_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_exc;
  logic [3:0]  out_exc_cause;
  logic [29:0] out_pc;

  csr_exec dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3), .in_rs1(in_rs1),
    .in_rs1_data(in_rs1_data), .in_rd(in_rd), .in_csr(in_csr), .in_pc(in_pc), .in_insn(in_insn),
    .flush(flush),
    .csr_addr(csr_addr), .csr_write(csr_write), .csr_wdata(csr_wdata),
    .csr_error(csr_error), .csr_rdata(csr_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_exc(out_exc), .out_exc_cause(out_exc_cause), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // CSR file model: mscratch, mstatus, and a free-running read-only cycle counter
  logic [31:0] m_mscratch = 32'h12;
  logic [31:0] m_mstatus  = 32'h1800;
  logic [31:0] m_cyc      = 32'd0;

  always_comb begin
    csr_rdata = 32'd0;
    csr_error = 1'b0;
    case (csr_addr)
      12'h340: csr_rdata = m_mscratch;
      12'h300: csr_rdata = m_mstatus;
      12'hC00: csr_rdata = m_cyc;
      default: csr_error = 1'b1;
    endcase
  end

  function automatic logic [31:0] apply(input logic [31:0] v, input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'b01:   return d;
      2'b10:   return v | d;
      2'b11:   return v & ~d;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    m_cyc <= m_cyc + 32'd1;
    if (csr_write != 2'b00) begin
      if (csr_addr == 12'h340) m_mscratch <= apply(m_mscratch, csr_write, csr_wdata);
      if (csr_addr == 12'h300) m_mstatus  <= apply(m_mstatus, csr_write, csr_wdata);
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [29:0] pc;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  logic [29:0] pc_ctr = 30'h100;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_insn(input string tag, input logic [2:0] f3, input logic [4:0] rs1,
                          input logic [31:0] rs1d, input logic [4:0] rd, input logic [11:0] csr,
                          input logic [1:0] exp_wr, input logic [31:0] exp_old, input logic exp_exc,
                          input logic use_cyc, input int stall, input logic flush_commit);
    logic [31:0] insn;
    logic [29:0] pc;
    exp_t        e;
    logic [31:0] held;
    insn = {csr, rs1, f3, rd, 7'h73};
    pc   = pc_ctr;
    pc_ctr++;
    @(negedge clk);
    check_eq({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = rs1; in_rs1_data = rs1d;
    in_rd = rd; in_csr = csr; in_pc = pc; in_insn = insn;
    @(posedge clk); #1 in_valid = 1'b0;
    // CHECK
    @(negedge clk);
    check_eq({tag, ".chk_wr"}, csr_write, 0);
    check_eq({tag, ".chk_addr"}, csr_addr, csr);
    check_eq({tag, ".chk_rdy"}, in_ready, 0);
    if (use_cyc) exp_old = m_cyc;
    if (!flush_commit) begin
      e.rd   = exp_exc ? 5'd0 : rd;
      e.data = exp_exc ? insn : exp_old;
      e.exc  = exp_exc;
      e.pc   = pc;
      sb.push_back(e);
    end
    // COMMIT
    @(posedge clk); #1 flush = flush_commit;
    @(negedge clk);
    check_eq({tag, ".commit_wr"}, csr_write, flush_commit ? 2'b00 : exp_wr);
    check_eq({tag, ".commit_vld"}, out_valid, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    if (flush_commit) begin
      check_eq({tag, ".flush_vld"}, out_valid, 0);
      check_eq({tag, ".flush_rdy"}, in_ready, 1);
      return;
    end
    // RESP
    check_eq({tag, ".out_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, ".rd"}, out_rd, e.rd);
    check_eq({tag, ".data"}, out_data, e.data);
    check_eq({tag, ".exc"}, out_exc, e.exc);
    check_eq({tag, ".cause"}, out_exc_cause, e.exc ? 4'd2 : 4'd0);
    check_eq({tag, ".pc"}, out_pc, e.pc);
    held = out_data;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_eq({tag, ".stall_vld"}, out_valid, 1);
      check_eq({tag, ".stall_data"}, out_data, held);
      check_eq({tag, ".stall_rd"}, out_rd, e.rd);
      check_eq({tag, ".stall_rdy"}, in_ready, 0);
      check_eq({tag, ".stall_wr"}, csr_write, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, ".done_vld"}, out_valid, 0);
    check_eq({tag, ".done_rdy"}, in_ready, 1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_funct3 = '0; in_rs1 = '0; in_rs1_data = '0; in_rd = '0; in_csr = '0; in_pc = '0; in_insn = '0;
    #1;
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.in_ready", in_ready, 1);
    check_eq("rst.csr_write", csr_write, 0);
    check_eq("rst.csr_addr", csr_addr, 0);
    check_eq("rst.out_data", out_data, 0);
    check_eq("rst.out_exc", out_exc, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_insn("csrrw_mscratch", 3'b001, 5'd7, 32'hDEADBEEF, 5'd5, 12'h340, 2'b01, 32'h12, 0, 0, 0, 0);
    check_eq("mscratch_after_rw", m_mscratch, 32'hDEADBEEF);
    run_insn("csrrs_read", 3'b010, 5'd0, 32'hFFFF_FFFF, 5'd6, 12'h340, 2'b00, 32'hDEADBEEF, 0, 0, 0, 0);
    run_insn("csrrsi_zero", 3'b110, 5'd0, 32'h0, 5'd1, 12'h300, 2'b00, 32'h1800, 0, 0, 0, 0);
    run_insn("csrrc_unimpl", 3'b011, 5'd3, 32'h5, 5'd2, 12'h7FF, 2'b00, 32'h0, 1, 0, 0, 0);
`ifdef CSR_RO_TRAP_EN
    run_insn("csrrw_ro", 3'b001, 5'd4, 32'h55, 5'd3, 12'hC00, 2'b00, 32'h0, 1, 0, 0, 0);
`else
    run_insn("csrrw_ro", 3'b001, 5'd4, 32'h55, 5'd3, 12'hC00, 2'b00, 32'h0, 0, 1, 0, 0);
`endif
    run_insn("csrrs_flush", 3'b010, 5'd9, 32'h0F, 5'd4, 12'h340, 2'b10, 32'hDEADBEEF, 0, 0, 0, 1);
    check_eq("mscratch_after_flush", m_mscratch, 32'hDEADBEEF);
    run_insn("csrrci_stall", 3'b111, 5'd5, 32'h0, 5'd8, 12'h340, 2'b11, 32'hDEADBEEF, 0, 0, 5, 0);
    run_insn("csrrs_readback", 3'b010, 5'd0, 32'h0, 5'd9, 12'h340, 2'b00, 32'hDEADBEEA, 0, 0, 0, 0);
    run_insn("funct3_zero", 3'b000, 5'd1, 32'h1, 5'd11, 12'h340, 2'b00, 32'h0, 1, 0, 0, 0);
    run_insn("csrrsi_mstatus", 3'b110, 5'd8, 32'h0, 5'd10, 12'h300, 2'b10, 32'h1800, 0, 0, 1, 0);
    check_eq("mstatus_after_set", m_mstatus, 32'h1808);

    // flush in IDLE blocks a same-cycle in_valid
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'b001; in_csr = 12'h340; in_rs1 = 5'd1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush.in_ready", in_ready, 1);
    check_eq("idle_flush.csr_write", csr_write, 0);
    @(negedge clk);
    check_eq("idle_flush.out_valid", out_valid, 0);

    // asynchronous reset while in CHECK
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b001; in_rs1 = 5'd2; in_rs1_data = 32'h1; in_rd = 5'd1;
    in_csr = 12'h340; in_pc = pc_ctr; in_insn = 32'h34011073;
    @(posedge clk); #1 in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid.in_ready", in_ready, 1);
    check_eq("rst_mid.out_valid", out_valid, 0);
    check_eq("rst_mid.csr_write", csr_write, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_mid.no_write", csr_write, 0);
      check_eq("rst_mid.no_valid", out_valid, 0);
    end
    check_eq("rst_mid.mscratch", m_mscratch, 32'hDEADBEEA);
    check_eq("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
